// File: rtl/pipe_ctrl_n.sv
// Pipeline controller: prioritised stall vector, registered branch redirect
// with a stall-tolerant front-end flush, and a saturating stall-cycle counter.
module pipe_ctrl_n #(
  parameter int unsigned STAGES       = 6,
  parameter int unsigned NREQ         = 3,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req_i,
  input  logic              br_valid_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              cnt_clr_i,
  output logic [STAGES-1:0] stall_o,
  output logic              redirect_valid_o,
  output logic [ADDR_W-1:0] redirect_addr_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                acc_q, acc_d;
  logic                rv_d;
  int unsigned         hi;

  // Highest requesting stage wins; it and everything upstream of it hold.
  always_comb begin
    hi = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (stall_req_i[k]) hi = k + 3;
    end
    for (int unsigned j = 0; j < STAGES; j++) begin
      stall_o[j] = !rst && (j < hi);
    end
  end

  // Next-state logic; progress through FLUSH only on cycles the PC is free.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fcnt_d  = fcnt_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (br_valid_i && br_taken_i) begin
          state_d = FLUSH;
          addr_d  = br_target_i;
          fcnt_d  = FW'(FLUSH_CYCLES);
          acc_d   = 1'b0;
        end
      end
      FLUSH: begin
        if (!stall_o[0]) begin
          acc_d  = 1'b1;
          fcnt_d = fcnt_q - FW'(1);
          if (fcnt_q == FW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rv_d = (state_d == FLUSH) && !acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      fcnt_q           <= '0;
      acc_q            <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_addr_o  <= '0;
      flush_o          <= 1'b0;
      busy_o           <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      fcnt_q           <= fcnt_d;
      acc_q            <= acc_d;
      redirect_valid_o <= rv_d;
      redirect_addr_o  <= rv_d ? addr_d : '0;
      flush_o          <= (state_d == FLUSH);
      busy_o           <= (state_d == FLUSH);
    end
  end

  // Clear beats increment; counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o[0] && (stall_cnt_o != CNT_MAX)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Bench for pipe_ctrl_n: two instances (FLUSH_CYCLES 2 and 1) driven in lockstep,
// checked against a cycle model through per-instance expectation queues.
module tb_pipe_ctrl_n;

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        fl;
    logic        bz;
    logic [3:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  stall_req = '0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        cnt_clr = 1'b0;

  logic [5:0]  a_stall, b_stall;
  logic        a_rv, b_rv, a_fl, b_fl, a_bz, b_bz;
  logic [31:0] a_ra, b_ra;
  logic [3:0]  a_cnt, b_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic saw_2000 = 1'b0;

  exp_t qa[$];
  exp_t qb[$];

  // Model state, index 0 = dut_a, 1 = dut_b
  logic        m_busy[2];
  logic        m_pend[2];
  int          m_left[2];
  logic [31:0] m_addr[2];
  int          m_cnt[2];
  int          fc[2] = '{2, 1};

  always #5 clk = ~clk;

  pipe_ctrl_n #(.STAGES(6), .NREQ(3), .ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .stall_req_i(stall_req), .br_valid_i(br_valid),
    .br_taken_i(br_taken), .br_target_i(br_target), .cnt_clr_i(cnt_clr),
    .stall_o(a_stall), .redirect_valid_o(a_rv), .redirect_addr_o(a_ra),
    .flush_o(a_fl), .busy_o(a_bz), .stall_cnt_o(a_cnt)
  );

  pipe_ctrl_n #(.STAGES(6), .NREQ(3), .ADDR_W(32), .FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .stall_req_i(stall_req), .br_valid_i(br_valid),
    .br_taken_i(br_taken), .br_target_i(br_target), .cnt_clr_i(cnt_clr),
    .stall_o(b_stall), .redirect_valid_o(b_rv), .redirect_addr_o(b_ra),
    .flush_o(b_fl), .busy_o(b_bz), .stall_cnt_o(b_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_stall(input logic [2:0] req, input logic r);
    logic [5:0] v;
    int top;
    top = 0;
    if (req[0]) top = 3;
    if (req[1]) top = 4;
    if (req[2]) top = 5;
    v = '0;
    for (int j = 0; j < 6; j++) if (j < top) v[j] = 1'b1;
    return r ? 6'b0 : v;
  endfunction

  // Drive one cycle, predict post-edge outputs, then check after the edge.
  task automatic cycle(input logic [2:0] req, input logic bv, input logic bt,
                       input logic [31:0] tgt, input logic clr, input logic r);
    logic [5:0] es;
    logic s0;
    exp_t e;
    stall_req = req; br_valid = bv; br_taken = bt; br_target = tgt;
    cnt_clr = clr; rst = r;
    #1;
    es = exp_stall(req, r);
    chk("stall_a", 64'(a_stall), 64'(es));
    chk("stall_b", 64'(b_stall), 64'(es));
    s0 = es[0];
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        m_busy[i] = 1'b0; m_pend[i] = 1'b0; m_left[i] = 0; m_addr[i] = '0; m_cnt[i] = 0;
      end else begin
        if (clr) m_cnt[i] = 0;
        else if (s0 && m_cnt[i] < 15) m_cnt[i]++;
        if (!m_busy[i]) begin
          if (bv && bt) begin
            m_busy[i] = 1'b1; m_pend[i] = 1'b1; m_left[i] = fc[i]; m_addr[i] = tgt;
          end
        end else if (!s0) begin
          m_pend[i] = 1'b0;
          m_left[i]--;
          if (m_left[i] == 0) m_busy[i] = 1'b0;
        end
      end
      e.rv  = m_busy[i] && m_pend[i];
      e.ra  = e.rv ? m_addr[i] : 32'h0;
      e.fl  = m_busy[i];
      e.bz  = m_busy[i];
      e.cnt = 4'(m_cnt[i]);
      if (i == 0) qa.push_back(e); else qb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (a_ra == 32'h2000 || b_ra == 32'h2000) saw_2000 = 1'b1;
    if (qa.size() == 0 || qb.size() == 0) begin
      chk("queue_underflow", 64'(qa.size()), 64'd1);
    end else begin
      e = qa.pop_front();
      chk("a_rv", 64'(a_rv), 64'(e.rv));
      chk("a_ra", 64'(a_ra), 64'(e.ra));
      chk("a_flush", 64'(a_fl), 64'(e.fl));
      chk("a_busy", 64'(a_bz), 64'(e.bz));
      chk("a_cnt", 64'(a_cnt), 64'(e.cnt));
      e = qb.pop_front();
      chk("b_rv", 64'(b_rv), 64'(e.rv));
      chk("b_ra", 64'(b_ra), 64'(e.ra));
      chk("b_flush", 64'(b_fl), 64'(e.fl));
      chk("b_busy", 64'(b_bz), 64'(e.bz));
      chk("b_cnt", 64'(b_cnt), 64'(e.cnt));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 1'b0; m_pend[i] = 1'b0; m_left[i] = 0; m_addr[i] = '0; m_cnt[i] = 0;
    end

    // Reset with requests and a branch present: all dropped
    cycle(3'b111, 1'b1, 1'b1, 32'hDEAD_0000, 1'b0, 1'b1);
    cycle(3'b111, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_rv", 64'(a_rv), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);

    // Stall priority, including rst masking
    stall_req = 3'b001; rst = 1'b0; #1; chk("prio_001", 64'(a_stall), 64'h07);
    stall_req = 3'b011; #1; chk("prio_011", 64'(a_stall), 64'h0F);
    stall_req = 3'b110; #1; chk("prio_110", 64'(a_stall), 64'h1F);
    stall_req = 3'b000; #1; chk("prio_000", 64'(a_stall), 64'h00);
    stall_req = 3'b110; rst = 1'b1; #1; chk("prio_rst", 64'(a_stall), 64'h00);
    @(posedge clk); #1;
    cycle(3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    idle(1);

    // Not-taken branch ignored
    cycle(3'b000, 1'b1, 1'b0, 32'h0000_0BAD, 1'b0, 1'b0);
    chk("nt_flush", 64'(a_fl), 64'd0);
    idle(1);

    // Unstalled redirect, FLUSH_CYCLES=2 on dut_a
    cycle(3'b000, 1'b1, 1'b1, 32'h0000_1040, 1'b0, 1'b0);
    chk("t1_rv", 64'(a_rv), 64'd1);
    chk("t1_ra", 64'(a_ra), 64'h1040);
    chk("t1_fl", 64'(a_fl), 64'd1);
    idle(1);
    chk("t2_rv", 64'(a_rv), 64'd0);
    chk("t2_ra", 64'(a_ra), 64'd0);
    chk("t2_fl", 64'(a_fl), 64'd1);
    idle(1);
    chk("t3_fl", 64'(a_fl), 64'd0);
    chk("t3_bz", 64'(a_bz), 64'd0);
    // Back-to-back event accepted on the IDLE return cycle
    cycle(3'b000, 1'b1, 1'b1, 32'h0000_1080, 1'b0, 1'b0);
    chk("b2b_ra", 64'(a_ra), 64'h1080);
    idle(3);

    // Event with MEM stall held t..t+3; dut_b has FLUSH_CYCLES=1
    cycle(3'b100, 1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
    chk("st1_rv", 64'(b_rv), 64'd1);
    chk("st1_ra", 64'(b_ra), 64'h3000);
    for (int i = 0; i < 3; i++) cycle(3'b100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("st4_rv", 64'(b_rv), 64'd1);
    chk("st4_ra", 64'(b_ra), 64'h3000);
    idle(1);
    chk("st5_fl", 64'(b_fl), 64'd0);
    chk("st5_rv", 64'(b_rv), 64'd0);
    idle(3);

    // Wrong-path event during FLUSH ignored
    saw_2000 = 1'b0;
    cycle(3'b000, 1'b1, 1'b1, 32'h0000_4000, 1'b0, 1'b0);
    cycle(3'b000, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0);
    chk("wp_b_fl", 64'(b_fl), 64'd0);
    idle(4);
    chk("wp_no2000", 64'(saw_2000), 64'd0);

    // Reset mid-FLUSH, then a fresh event
    cycle(3'b000, 1'b1, 1'b1, 32'h0000_4400, 1'b0, 1'b0);
    cycle(3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("mr_fl", 64'(a_fl), 64'd0);
    chk("mr_rv", 64'(a_rv), 64'd0);
    cycle(3'b000, 1'b1, 1'b1, 32'h0000_5000, 1'b0, 1'b0);
    chk("mr_new_rv", 64'(a_rv), 64'd1);
    chk("mr_new_ra", 64'(a_ra), 64'h5000);
    idle(3);

    // Counter saturation and clears
    cycle(3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(3'b001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("cnt_sat", 64'(a_cnt), 64'd15);
    cycle(3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("cnt_clr", 64'(a_cnt), 64'd0);
    cycle(3'b001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("cnt_one", 64'(a_cnt), 64'd1);
    cycle(3'b010, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("cnt_clr_st", 64'(a_cnt), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            $urandom, ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0));
    end

    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
